ddr3_assoc_cache_ctrl: RTL and testbench

DDR3_ASSOC_CACHE_CTRL -- requirements
Module: ddr3_assoc_cache_ctrl

---
 rtl/ddr3_cache_pkg.sv | 17 +
 rtl/cache_line_ram.sv | 18 +
 rtl/ddr3_assoc_cache_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_ddr3_assoc_cache_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ddr3_cache_pkg.sv
// Shared types and defaults for the DDR3 set-associative cache controller.
package ddr3_cache_pkg;
    localparam int ADDR_BITS_DEF = 29;
    localparam int LINE_BITS_DEF = 256;
    localparam int SETS_DEF      = 256;
    localparam int WAYS_DEF      = 2;
    localparam int OFFSET_BITS   = $clog2(LINE_BITS_DEF / 8);
    localparam int INDEX_BITS    = $clog2(SETS_DEF);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOKUP, S_MERGE, S_WRITEBACK, S_REFILL, S_END, S_FLUSH
    } state_e;

    function automatic int offset_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction
endpackage

// File: rtl/cache_line_ram.sv
// Single-port line store for one way; one-cycle read latency, line-wide write.
module cache_line_ram #(
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [LINE_BITS-1:0]     wdata_i,
    output logic [LINE_BITS-1:0]     rdata_o
);
    logic [LINE_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/ddr3_assoc_cache_ctrl.sv
// Write-back, write-allocate 1/2-way cache between a 32-bit bus and a line-wide DDR3 port.
module ddr3_assoc_cache_ctrl
    import ddr3_cache_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int SETS      = SETS_DEF,
    parameter int WAYS      = WAYS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          data_i,
    input  logic [3:0]           sel_i,
    input  logic                 rd_i,
    input  logic                 we_i,
    output logic [31:0]          data_o,
    output logic                 ack_o,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    output logic                 mem_we_o,
    output logic                 mem_rd_o,
    input  logic                 mem_ack_i
);
    localparam int OFF_W  = offset_bits(LINE_BITS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_BITS - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - 2;

    state_e state_q, state_d;

    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic             valid_q [WAYS][SETS];
    logic             dirty_q [WAYS][SETS];
    logic             lru_q   [SETS];

    logic [ADDR_BITS-1:0] req_addr_q;
    logic [31:0]          req_data_q;
    logic [3:0]           req_sel_q;
    logic                 req_we_q;
    logic                 way_q;
    logic [LINE_BITS-1:0] line_q;
    logic [IDX_W-1:0]     scan_q;
    logic                 scan_way_q, fl_phase_q, fl_last_q, flushing_q;
    logic                 ack_q, done_q, mem_we_q, mem_rd_q;
    logic [31:0]          data_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic [LINE_BITS-1:0] mem_wdata_q;

    logic [IDX_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;
    assign req_set  = req_addr_q[OFF_W +: IDX_W];
    assign req_tag  = req_addr_q[OFF_W+IDX_W +: TAG_W];
    assign req_word = req_addr_q[OFF_W-1:2];

    logic [LINE_BITS-1:0] rdata [WAYS];
    logic [WAYS-1:0]      ram_we;
    logic [IDX_W-1:0]     ram_addr;
    logic [LINE_BITS-1:0] ram_wdata, merged;
    logic                 hit, hit_way, victim, victim_dirty, fl_dirty, fl_is_last;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_line_ram #(.LINE_BITS(LINE_BITS), .DEPTH(SETS)) u_ram (
            .clk    (clk),
            .we_i   (ram_we[g]),
            .addr_i (ram_addr),
            .wdata_i(ram_wdata),
            .rdata_o(rdata[g])
        );
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (valid_q[w][req_set] && tag_q[w][req_set] == req_tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        if (!valid_q[0][req_set])                          victim = 1'b0;
        else if (WAYS == 2 && !valid_q[WAYS-1][req_set])   victim = 1'b1;
        else if (WAYS == 2)                                victim = lru_q[req_set];
        else                                               victim = 1'b0;
        victim_dirty = valid_q[victim][req_set] && dirty_q[victim][req_set];
        fl_dirty     = valid_q[scan_way_q][scan_q] && dirty_q[scan_way_q][scan_q];
        fl_is_last   = (scan_q == IDX_W'(SETS-1)) && (scan_way_q == 1'(WAYS-1));
    end

    // Byte-enable merge of the upstream word into the buffered line.
    always_comb begin
        merged = line_q;
        for (int b = 0; b < 4; b++)
            if (req_sel_q[b]) merged[32*int'(req_word) + 8*b +: 8] = req_data_q[8*b +: 8];
    end

    always_comb begin
        ram_addr  = (state_q == S_FLUSH) ? scan_q :
                    (state_q == S_IDLE)  ? addr_i[OFF_W +: IDX_W] : req_set;
        ram_wdata = (state_q == S_MERGE) ? merged : mem_rdata_i;
        for (int w = 0; w < WAYS; w++)
            ram_we[w] = (way_q == 1'(w)) &&
                        (state_q == S_MERGE || (state_q == S_REFILL && mem_ack_i));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      if (scan_q == IDX_W'(SETS-1)) state_d = S_IDLE;
            S_IDLE:      if (we_i || rd_i) state_d = S_LOOKUP;
                         else if (flush_i) state_d = S_FLUSH;
            S_LOOKUP:    if (hit)               state_d = req_we_q ? S_MERGE : S_END;
                         else if (victim_dirty) state_d = S_WRITEBACK;
                         else                   state_d = S_REFILL;
            S_MERGE:     state_d = S_END;
            S_WRITEBACK: if (mem_ack_i) state_d = flushing_q ? S_FLUSH : S_REFILL;
            S_REFILL:    if (mem_ack_i) state_d = req_we_q ? S_MERGE : S_END;
            S_END:       state_d = S_IDLE;
            S_FLUSH:     if (fl_last_q)                   state_d = S_IDLE;
                         else if (fl_phase_q && fl_dirty) state_d = S_WRITEBACK;
            default:     state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q      <= '0;
            scan_way_q  <= 1'b0;
            fl_phase_q  <= 1'b0;
            fl_last_q   <= 1'b0;
            flushing_q  <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_sel_q   <= '0;
            req_we_q    <= 1'b0;
            way_q       <= 1'b0;
            line_q      <= '0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ack_q    <= (state_d == S_END);
            done_q   <= (state_q == S_FLUSH) && fl_last_q;
            mem_we_q <= (state_d == S_WRITEBACK);
            mem_rd_q <= (state_d == S_REFILL);
            case (state_q)
                S_INIT: begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[w][scan_q] <= 1'b0;
                        dirty_q[w][scan_q] <= 1'b0;
                    end
                    lru_q[scan_q] <= 1'b0;
                    scan_q        <= scan_q + 1'b1;
                end
                S_IDLE: begin
                    req_addr_q <= addr_i[ADDR_BITS-1:0];
                    req_data_q <= data_i;
                    req_sel_q  <= sel_i;
                    req_we_q   <= we_i;
                    scan_q     <= '0;
                    scan_way_q <= 1'b0;
                    fl_phase_q <= 1'b0;
                    fl_last_q  <= 1'b0;
                    flushing_q <= !(we_i || rd_i) && flush_i;
                end
                S_LOOKUP: begin
                    way_q <= hit ? hit_way : victim;
                    if (hit) begin
                        line_q         <= rdata[hit_way];
                        lru_q[req_set] <= ~hit_way;
                        if (!req_we_q) data_q <= rdata[hit_way][32*int'(req_word) +: 32];
                    end else if (victim_dirty) begin
                        mem_addr_q  <= {tag_q[victim][req_set], req_set, {OFF_W{1'b0}}};
                        mem_wdata_q <= rdata[victim];
                    end else begin
                        mem_addr_q  <= {req_tag, req_set, {OFF_W{1'b0}}};
                    end
                end
                S_WRITEBACK:
                    if (mem_ack_i && !flushing_q) mem_addr_q <= {req_tag, req_set, {OFF_W{1'b0}}};
                S_REFILL:
                    if (mem_ack_i) begin
                        tag_q[way_q][req_set]   <= req_tag;
                        valid_q[way_q][req_set] <= 1'b1;
                        dirty_q[way_q][req_set] <= 1'b0;
                        lru_q[req_set]          <= ~way_q;
                        line_q                  <= mem_rdata_i;
                        if (!req_we_q) data_q <= mem_rdata_i[32*int'(req_word) +: 32];
                    end
                S_MERGE: dirty_q[way_q][req_set] <= 1'b1;
                // Two cycles per entry: phase 0 issues the RAM read, phase 1 consumes it.
                S_FLUSH:
                    if (!fl_last_q) begin
                        fl_phase_q <= !fl_phase_q;
                        if (fl_phase_q) begin
                            if (fl_dirty) begin
                                mem_addr_q  <= {tag_q[scan_way_q][scan_q], scan_q, {OFF_W{1'b0}}};
                                mem_wdata_q <= rdata[scan_way_q];
                            end
                            valid_q[scan_way_q][scan_q] <= 1'b0;
                            dirty_q[scan_way_q][scan_q] <= 1'b0;
                            if (fl_is_last) fl_last_q <= 1'b1;
                            else if (scan_way_q == 1'(WAYS-1)) begin
                                scan_way_q <= 1'b0;
                                scan_q     <= scan_q + 1'b1;
                            end else begin
                                scan_way_q <= 1'b1;
                            end
                        end
                    end
                default: ;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:ADDR_BITS], req_addr_q[1:0]};

    assign ack_o        = ack_q;
    assign data_o       = data_q;
    assign flush_done_o = done_q;
    assign mem_we_o     = mem_we_q;
    assign mem_rd_o     = mem_rd_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
endmodule

// File: tb/tb_ddr3_assoc_cache_ctrl.sv
// Scoreboard bench: stimulus queues expected bus data and memory handshakes, monitors compare.
module tb_ddr3_assoc_cache_ctrl;
    logic         clk = 0, rst = 1;
    logic [31:0]  addr_i = 0, data_i = 0;
    logic [3:0]   sel_i = 0;
    logic         rd_i = 0, we_i = 0, flush_i = 0;
    logic [31:0]  data_o;
    logic         ack_o, flush_done_o;
    logic [28:0]  mem_addr_o;
    logic [255:0] mem_wdata_o, mem_rdata_i = 0;
    logic         mem_we_o, mem_rd_o, mem_ack_i = 0;

    ddr3_assoc_cache_ctrl dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .rd_i(rd_i), .we_i(we_i), .data_o(data_o), .ack_o(ack_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_we_o(mem_we_o), .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        int          widx;
        logic [31:0] wword;
    } memexp_t;

    memexp_t     exp_mem[$];
    logic [31:0] exp_data[$];
    memexp_t     m;
    int          errors = 0, checks = 0, wcount = 0, wc0, n;
    bit          hold_ack = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory contents: word k of line a is C000_0000 | a<<4 | k; line 0x40 carries DEADBEEF.
    function automatic logic [255:0] line_for(input logic [28:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hC000_0000 | ({3'b0, a} << 4) | 32'(k);
        if (a == 29'h40) begin
            l[31:0]  = 32'hDEADBEEF;
            l[95:64] = 32'hDEADBEEF;
        end
        return l;
    endfunction

    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            mem_ack_i = 0;
            if ((mem_rd_o || mem_we_o) && !rst && !hold_ack) begin
                cnt++;
                if (cnt == 3) begin
                    mem_ack_i   = 1;
                    mem_rdata_i = line_for(mem_addr_o);
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mem_rd_o && mem_we_o) chk("strobe_overlap", 1, 0);
        if (mem_ack_i && (mem_rd_o || mem_we_o)) begin
            if (exp_mem.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_unexpected: got we=%0d addr=%h expected no traffic", mem_we_o, mem_addr_o);
            end else begin
                m = exp_mem.pop_front();
                chk("mem_we", {63'd0, mem_we_o}, {63'd0, m.we});
                chk("mem_addr", {35'd0, mem_addr_o}, {32'd0, m.addr});
                if (m.we) chk("mem_wdata", {32'd0, mem_wdata_o[m.widx*32 +: 32]}, {32'd0, m.wword});
            end
            if (mem_we_o) wcount++;
        end
    end

    always @(negedge clk) begin
        if (ack_o) begin
            if (exp_data.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack_unexpected: got ack with data %h expected none", data_o);
            end else chk("data_o", {32'd0, data_o}, {32'd0, exp_data.pop_front()});
        end
    end

    task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp, input int exp_lat);
        int k;
        exp_data.push_back(exp);
        @(posedge clk); #1;
        addr_i = a; data_i = d; sel_i = s; we_i = w; rd_i = !w;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!ack_o && k < 300);
        rd_i = 0; we_i = 0;
        if (!ack_o) chk("req_timeout", 0, 1);
        else if (exp_lat > 0) chk("latency", 64'(k), 64'(exp_lat));
    endtask

    task automatic exp_rd(input logic [31:0] a);
        exp_mem.push_back('{we: 1'b0, addr: a, widx: 0, wword: 32'h0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input int wi, input logic [31:0] wd);
        exp_mem.push_back('{we: 1'b1, addr: a, widx: wi, wword: wd});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {63'd0, ack_o}, 0);
        chk("rst_done", {63'd0, flush_done_o}, 0);
        chk("rst_mem_we", {63'd0, mem_we_o}, 0);
        chk("rst_mem_rd", {63'd0, mem_rd_o}, 0);
        chk("rst_data", {32'd0, data_o}, 0);
        chk("rst_mem_addr", {35'd0, mem_addr_o}, 0);
        rst = 0;
        repeat (260) @(posedge clk);

        exp_rd(32'h40);
        req(0, 32'h40, 0, 4'h0, 32'hDEADBEEF, 0);            // cold miss
        req(0, 32'h40, 0, 4'h0, 32'hDEADBEEF, 2);            // hit
        req(1, 32'h44, 32'h11223344, 4'b0011, 32'hDEADBEEF, 3); // write hit, word 1
        req(0, 32'h44, 0, 4'h0, 32'hC000_3344, 2);
        exp_rd(32'h2040);
        req(0, 32'h2040, 0, 4'h0, 32'hC002_0400, 0);
        exp_wr(32'h40, 1, 32'hC000_3344);
        exp_rd(32'h4040);
        req(0, 32'h4040, 0, 4'h0, 32'hC004_0400, 0);         // evicts dirty 0x40
        req(1, 32'h2044, 32'hAABBCCDD, 4'hF, 32'hC004_0400, 3);
        exp_rd(32'h60);
        req(1, 32'h60, 32'h55667788, 4'hF, 32'hC004_0400, 0); // write miss allocates

        wc0 = wcount;
        exp_wr(32'h2040, 1, 32'hAABBCCDD);
        exp_wr(32'h60, 0, 32'h55667788);
        @(posedge clk); #1 flush_i = 1;
        @(posedge clk); #1 flush_i = 0;
        n = 0;
        while (!flush_done_o && n < 5000) begin @(posedge clk); #1; n++; end
        chk("flush_done", {63'd0, flush_done_o}, 1);
        @(posedge clk); #1;
        chk("flush_done_pulse", {63'd0, flush_done_o}, 0);
        chk("flush_wb_count", 64'(wcount - wc0), 2);

        exp_rd(32'h2040);
        req(0, 32'h2040, 0, 4'h0, 32'hC002_0400, 0);
        exp_rd(32'h40);
        req(0, 32'h40, 0, 4'h0, 32'hDEADBEEF, 0);

        hold_ack = 1;
        @(posedge clk); #1 addr_i = 32'h1000; rd_i = 1;
        n = 0;
        while (!mem_rd_o && n < 50) begin @(posedge clk); #1; n++; end
        chk("rd_strobe_pending", {63'd0, mem_rd_o}, 1);
        rst = 1; rd_i = 0;
        @(posedge clk); #1;
        chk("mem_rd_after_rst", {63'd0, mem_rd_o}, 0);
        chk("data_after_rst", {32'd0, data_o}, 0);
        @(posedge clk); #1 rst = 0; hold_ack = 0;
        repeat (260) @(posedge clk);
        exp_rd(32'h40);
        req(0, 32'h40, 0, 4'h0, 32'hDEADBEEF, 0);

        repeat (5) @(posedge clk);
        chk("mem_queue_empty", 64'(exp_mem.size()), 0);
        chk("data_queue_empty", 64'(exp_data.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
